// File: rtl/rr_stream_mux.sv
// Stream multiplexer with one registered output stage. Each cycle it picks one of N
// channels, either by fixed select or by round-robin arbitration.
module rr_stream_mux #(
    parameter int WIDTH = 4,
    parameter int N     = 4,
    parameter int SW    = $clog2(N)
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_mode,
    input  logic [SW-1:0]      i_s,
    input  logic [N-1:0]       i_valid,
    input  logic [N*WIDTH-1:0] i_data,
    output logic [N-1:0]       o_ready,
    output logic               o_valid,
    output logic [WIDTH-1:0]   o_data,
    output logic [SW-1:0]      o_sel,
    input  logic               i_ready
);

    localparam logic [SW:0] N_EXT = (SW+1)'(N);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    logic [SW-1:0]    r_sel;
    logic [SW-1:0]    r_ptr;

    logic             w_load;
    logic             w_rr_found;
    logic [SW-1:0]    w_rr_idx;
    logic [SW:0]      w_scan_ext;
    logic             w_fix_ok;
    logic [SW-1:0]    w_cand;
    logic             w_cand_ok;
    logic             w_grant;
    logic [WIDTH-1:0] w_cand_data;
    logic [SW:0]      w_ptr_inc;
    logic [SW-1:0]    w_ptr_next;

    assign w_load = !r_valid || i_ready;

    // Round-robin scan from r_ptr; walks farthest-first so the nearest requester wins.
    always_comb begin
        w_rr_found = 1'b0;
        w_rr_idx   = r_ptr;
        w_scan_ext = {(SW+1){1'b0}};
        for (int j = N - 1; j >= 0; j--) begin
            w_scan_ext = {1'b0, r_ptr} + (SW+1)'(j);
            if (w_scan_ext >= N_EXT) begin
                w_scan_ext = w_scan_ext - N_EXT;
            end else begin
                w_scan_ext = w_scan_ext;
            end
            if (i_valid[w_scan_ext[SW-1:0]]) begin
                w_rr_found = 1'b1;
                w_rr_idx   = w_scan_ext[SW-1:0];
            end else begin
                w_rr_found = w_rr_found;
            end
        end
    end

    // Candidate selection and grant qualification for both modes.
    always_comb begin
        w_fix_ok  = ({1'b0, i_s} < N_EXT);
        w_cand    = i_s;
        w_cand_ok = 1'b0;
        if (i_mode) begin
            w_cand    = w_rr_idx;
            w_cand_ok = w_rr_found;
        end else begin
            w_cand    = i_s;
            w_cand_ok = w_fix_ok && i_valid[i_s];
        end
        w_grant = !i_rst && w_load && w_cand_ok;
    end

    // One-hot handshake back to the granted channel.
    always_comb begin
        o_ready = {N{1'b0}};
        if (w_grant) begin
            o_ready = {{(N-1){1'b0}}, 1'b1} << w_cand;
        end else begin
            o_ready = {N{1'b0}};
        end
    end

    assign w_cand_data = i_data[w_cand*WIDTH +: WIDTH];

    // Pointer advance past the granted channel, wrapping at N (N need not be a power of two).
    always_comb begin
        w_ptr_inc  = {1'b0, w_cand} + {{SW{1'b0}}, 1'b1};
        w_ptr_next = w_ptr_inc[SW-1:0];
        if (w_ptr_inc >= N_EXT) begin
            w_ptr_next = {SW{1'b0}};
        end else begin
            w_ptr_next = w_ptr_inc[SW-1:0];
        end
    end

    // Output register and arbitration pointer; reset discards any held word.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_valid <= 1'b0;
            r_data  <= {WIDTH{1'b0}};
            r_sel   <= {SW{1'b0}};
            r_ptr   <= {SW{1'b0}};
        end else if (w_grant) begin
            r_valid <= 1'b1;
            r_data  <= w_cand_data;
            r_sel   <= w_cand;
            if (i_mode) begin
                r_ptr <= w_ptr_next;
            end else begin
                r_ptr <= r_ptr;
            end
        end else if (w_load) begin
            r_valid <= 1'b0;
        end else begin
            r_valid <= r_valid;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_sel   = r_sel;

endmodule

// File: tb/tb_rr_stream_mux.sv
// Scoreboard bench for rr_stream_mux: a 4-channel and a 3-channel instance, driven by directed
// steps whose expected grants are queued and checked by per-instance monitors as words are accepted.
`timescale 1ns/1ps
module tb_rr_stream_mux;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // 4-channel instance
    logic        rst = 1'b1, mode = 1'b0, iready = 1'b0;
    logic [1:0]  s = 2'd0;
    logic [3:0]  valid = 4'b0000;
    logic [15:0] data;
    logic [3:0]  ready_o;
    logic        ovalid;
    logic [3:0]  odata;
    logic [1:0]  osel;
    logic [3:0]  w4 [4];
    logic [5:0]  q4 [$];

    // 3-channel instance
    logic        rst3 = 1'b1, mode3 = 1'b0, iready3 = 1'b0;
    logic [1:0]  s3 = 2'd0;
    logic [2:0]  valid3 = 3'b000;
    logic [11:0] data3;
    logic [2:0]  ready3;
    logic        ovalid3;
    logic [3:0]  odata3;
    logic [1:0]  osel3;
    logic [3:0]  w3 [3];
    logic [5:0]  q3 [$];

    initial begin
        w4[0] = 4'b1111; w4[1] = 4'b0000; w4[2] = 4'b0011; w4[3] = 4'b0101;
        w3[0] = 4'b1100; w3[1] = 4'b0110; w3[2] = 4'b1001;
    end
    assign data  = {w4[3], w4[2], w4[1], w4[0]};
    assign data3 = {w3[2], w3[1], w3[0]};

    rr_stream_mux #(.WIDTH(4), .N(4)) dut4 (
        .i_clk(clk), .i_rst(rst), .i_mode(mode), .i_s(s), .i_valid(valid), .i_data(data),
        .o_ready(ready_o), .o_valid(ovalid), .o_data(odata), .o_sel(osel), .i_ready(iready)
    );

    rr_stream_mux #(.WIDTH(4), .N(3)) dut3 (
        .i_clk(clk), .i_rst(rst3), .i_mode(mode3), .i_s(s3), .i_valid(valid3), .i_data(data3),
        .o_ready(ready3), .o_valid(ovalid3), .o_data(odata3), .o_sel(osel3), .i_ready(iready3)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Drive one cycle on dut4, check o_ready, queue the expected accepted word.
    task automatic step4(input logic r, input logic m, input logic [1:0] sv, input logic [3:0] v,
                         input logic rd, input logic [3:0] exp_rdy, input logic push, input string nm);
        rst = r; mode = m; s = sv; valid = v; iready = rd;
        #1;
        check(nm, 32'(ready_o), 32'(exp_rdy));
        if (push) begin
            for (int k = 0; k < 4; k++) begin
                if (exp_rdy[k]) q4.push_back({w4[k], 2'(k)});
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic step3(input logic r, input logic m, input logic [1:0] sv, input logic [2:0] v,
                         input logic rd, input logic [2:0] exp_rdy, input logic push, input string nm);
        rst3 = r; mode3 = m; s3 = sv; valid3 = v; iready3 = rd;
        #1;
        check(nm, 32'(ready3), 32'(exp_rdy));
        if (push) begin
            for (int k = 0; k < 3; k++) begin
                if (exp_rdy[k]) q3.push_back({w3[k], 2'(k)});
            end
        end
        @(posedge clk); #1;
    endtask

    // Monitor dut4: compare every word taken by the downstream against the scoreboard.
    always @(negedge clk) begin
        if (!rst && ovalid && iready) begin
            if (q4.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL mon4_extra: got data %b sel %0d expected no word", odata, osel);
            end else begin
                check("mon4_word", 32'({odata, osel}), 32'(q4.pop_front()));
            end
        end
    end

    // Monitor dut3.
    always @(negedge clk) begin
        if (!rst3 && ovalid3 && iready3) begin
            if (q3.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL mon3_extra: got data %b sel %0d expected no word", odata3, osel3);
            end else begin
                check("mon3_word", 32'({odata3, osel3}), 32'(q3.pop_front()));
            end
        end
    end

    initial begin
        logic [3:0] e4;
        logic [2:0] e3;
        @(posedge clk); #1;
        // reset: o_ready suppressed, outputs cleared
        step4(1'b1, 1'b1, 2'd0, 4'b1111, 1'b1, 4'b0000, 1'b0, "rst_ready_a");
        step4(1'b1, 1'b0, 2'd2, 4'b1111, 1'b1, 4'b0000, 1'b0, "rst_ready_b");
        check("rst_valid", 32'(ovalid), 32'd0);
        check("rst_data", 32'(odata), 32'd0);
        check("rst_sel", 32'(osel), 32'd0);

        // fixed select walk
        for (int i = 0; i < 4; i++) begin
            e4 = 4'b0001 << i;
            step4(1'b0, 1'b0, 2'(i), 4'b1111, 1'b1, e4, 1'b1, "fix_ready");
        end
        check("fix_lat_valid", 32'(ovalid), 32'd1);

        // round robin, all requesting
        for (int i = 0; i < 8; i++) begin
            e4 = 4'b0001 << (i % 4);
            step4(1'b0, 1'b1, 2'd0, 4'b1111, 1'b1, e4, 1'b1, "rr_ready");
        end

        // backpressure: hold 0011 for three cycles while inputs move
        step4(1'b0, 1'b0, 2'd2, 4'b1111, 1'b1, 4'b0100, 1'b1, "bp_load");
        step4(1'b0, 1'b0, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b0, "bp_ready_a");
        check("bp_data_a", 32'(odata), 32'b0011);
        step4(1'b0, 1'b1, 2'd3, 4'b0101, 1'b0, 4'b0000, 1'b0, "bp_ready_b");
        check("bp_data_b", 32'(odata), 32'b0011);
        step4(1'b0, 1'b0, 2'd1, 4'b0000, 1'b0, 4'b0000, 1'b0, "bp_ready_c");
        check("bp_data_c", 32'(odata), 32'b0011);
        check("bp_sel", 32'(osel), 32'd2);
        check("bp_valid", 32'(ovalid), 32'd1);
        step4(1'b0, 1'b0, 2'd1, 4'b1111, 1'b1, 4'b0010, 1'b1, "bp_release");
        step4(1'b0, 1'b0, 2'd0, 4'b0000, 1'b1, 4'b0000, 1'b0, "bp_drain");
        check("bp_drain_valid", 32'(ovalid), 32'd0);

        // sparse round robin: ch1 grant moves ptr to 2, then 3,1,3
        step4(1'b0, 1'b1, 2'd0, 4'b0010, 1'b1, 4'b0010, 1'b1, "sp_setup");
        step4(1'b0, 1'b1, 2'd0, 4'b1010, 1'b1, 4'b1000, 1'b1, "sp_g0");
        step4(1'b0, 1'b1, 2'd0, 4'b1010, 1'b1, 4'b0010, 1'b1, "sp_g1");
        step4(1'b0, 1'b1, 2'd0, 4'b1010, 1'b1, 4'b1000, 1'b1, "sp_g2");
        step4(1'b0, 1'b1, 2'd0, 4'b0000, 1'b1, 4'b0000, 1'b0, "sp_idle");
        check("sp_idle_valid", 32'(ovalid), 32'd0);

        // reset while holding an unaccepted word (ch2), then ptr restarts at ch0
        step4(1'b0, 1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, "mr_g0");
        step4(1'b0, 1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1, "mr_g1");
        step4(1'b0, 1'b1, 2'd0, 4'b1111, 1'b1, 4'b0100, 1'b0, "mr_g2");
        check("mr_held", 32'({ovalid, odata}), 32'b1_0011);
        step4(1'b1, 1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b0, "mr_rst_ready");
        check("mr_valid", 32'(ovalid), 32'd0);
        check("mr_data", 32'(odata), 32'd0);
        check("mr_sel", 32'(osel), 32'd0);
        step4(1'b0, 1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, "mr_after");
        step4(1'b0, 1'b1, 2'd0, 4'b0000, 1'b1, 4'b0000, 1'b0, "mr_drain");
        step4(1'b0, 1'b1, 2'd0, 4'b0000, 1'b1, 4'b0000, 1'b0, "mr_idle");
        check("q4_empty", 32'(q4.size()), 32'd0);

        // 3-channel instance: out-of-range select and wrap 2 -> 0
        step3(1'b1, 1'b1, 2'd0, 3'b111, 1'b1, 3'b000, 1'b0, "n3_rst");
        step3(1'b0, 1'b0, 2'd3, 3'b111, 1'b1, 3'b000, 1'b0, "n3_fix_s3");
        check("n3_fix_s3_valid", 32'(ovalid3), 32'd0);
        step3(1'b0, 1'b0, 2'd2, 3'b111, 1'b1, 3'b100, 1'b1, "n3_fix_s2");
        for (int i = 0; i < 4; i++) begin
            e3 = 3'b001 << (i % 3);
            step3(1'b0, 1'b1, 2'd0, 3'b111, 1'b1, e3, 1'b1, "n3_rr");
        end
        step3(1'b0, 1'b1, 2'd0, 3'b000, 1'b1, 3'b000, 1'b0, "n3_drain");
        step3(1'b0, 1'b1, 2'd0, 3'b000, 1'b1, 3'b000, 1'b0, "n3_idle");
        check("n3_idle_valid", 32'(ovalid3), 32'd0);
        check("q3_empty", 32'(q3.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
